dm_arbiter: RTL and testbench

Sequencer and two-way arbiter for the single-port data memory used by the memory stage. It shares the DM between the pipeline M-stage load/store port and a DMA/loader port. It issues one access at a time and counts out the DM read latency. It raises a stall to the pipeline whenever the M-stage access cannot complete in the current cycle. It sits between the M-stage register outputs and the DM instance.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_lat_cnt.sv | 28 ++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and limits for the data-memory arbiter.
// Holds the FSM state, the read-owner encoding and the legal DM latency range.
package dm_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   typedef enum logic {
      OWN_M = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int DM_LAT_MIN = 1;
   localparam int DM_LAT_MAX = 3;

endpackage

// File: rtl/dm_lat_cnt.sv
// Loadable down-counter that times the DM read latency.
// 'done' marks the final wait cycle (count == 1).
module dm_lat_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         done
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/dm_arbiter.sv
// Two-way arbiter and sequencer for the single-port data memory, shared by
// the pipeline M-stage load/store port and a DMA/loader port.
import dm_arb_pkg::*;

module dm_arbiter #(
   parameter int DM_LAT = 1,
   parameter int AW     = 32,
   parameter int DW     = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m_req,
   input  logic          m_we,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_wdata,
   input  logic [31:0]   m_pc,
   output logic          m_stall,
   output logic          m_rvalid,
   output logic [DW-1:0] m_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          dm_en,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   output logic [31:0]   dm_pc,
   input  logic [DW-1:0] dm_rdata
);

   if ((DM_LAT < DM_LAT_MIN) || (DM_LAT > DM_LAT_MAX)) begin : g_bad_lat
      $error("dm_arbiter: DM_LAT out of range 1..3");
   end

   state_t     state_q, state_d;
   owner_t     owner_q, owner_d;
   owner_t     last_q,  last_d;
   logic [1:0] cnt;
   logic       cnt_done;

   logic m_win, d_win, issue, issue_we, rd_issue, rd_done;

   // Arbitration is only live in IDLE and never while reset is held.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      m_win = 1'b0;
      d_win = 1'b0;
      if (reset && (state_q == IDLE)) begin
         if (m_req && d_req) begin
            m_win = (last_q == OWN_D);
            d_win = (last_q == OWN_M);
         end else begin
            m_win = m_req;
            d_win = d_req;
         end
      end
   end

   assign issue    = m_win | d_win;
   assign issue_we = m_win ? m_we : d_we;
   assign rd_issue = issue & ~issue_we;
   assign rd_done  = reset & (state_q == RD_WAIT) & cnt_done;

   dm_lat_cnt #(.W(2)) u_lat_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (rd_issue),
      .load_val (2'(DM_LAT)),
      .dec      (state_q == RD_WAIT),
      .count    (cnt),
      .done     (cnt_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= OWN_M;
         last_q  <= OWN_D;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (rd_issue) begin
               state_d = RD_WAIT;
               owner_d = m_win ? OWN_M : OWN_D;
            end
            if (m_req && d_req && issue) begin
               last_d = m_win ? OWN_M : OWN_D;
            end
         end
         RD_WAIT: begin
            if (cnt_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic; DM fields are zero whenever no access is issued.
   always_comb begin
      dm_en    = issue;
      dm_we    = issue & issue_we;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_pc    = '0;
      if (m_win) begin
         dm_addr  = m_addr;
         dm_wdata = m_wdata;
         dm_pc    = m_pc;
      end else if (d_win) begin
         dm_addr  = d_addr;
         dm_wdata = d_wdata;
      end

      d_gnt    = d_win;
      m_rvalid = rd_done & (owner_q == OWN_M);
      d_rvalid = rd_done & (owner_q == OWN_D);
      m_rdata  = m_rvalid ? dm_rdata : '0;
      d_rdata  = d_rvalid ? dm_rdata : '0;
      m_stall  = reset & m_req & ~((m_win & m_we) | m_rvalid);
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter: instance 'a' with DM_LAT=2,
// instance 'b' with DM_LAT=3 for the DMA-only read.
module tb_dm_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A (DM_LAT = 2)
   logic        m_req, m_we, d_req, d_we;
   logic [31:0] m_addr, m_wdata, m_pc, d_addr, d_wdata;
   logic        m_stall, m_rvalid, d_gnt, d_rvalid, dm_en, dm_we;
   logic [31:0] m_rdata, d_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;

   // Instance B (DM_LAT = 3)
   logic        b_m_req, b_m_we, b_d_req, b_d_we;
   logic [31:0] b_m_addr, b_m_wdata, b_m_pc, b_d_addr, b_d_wdata;
   logic        b_m_stall, b_m_rvalid, b_d_gnt, b_d_rvalid, b_dm_en, b_dm_we;
   logic [31:0] b_m_rdata, b_d_rdata, b_dm_addr, b_dm_wdata, b_dm_pc, b_dm_rdata;

   dm_arbiter #(.DM_LAT(2), .AW(32), .DW(32)) u_a (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_pc(m_pc),
      .m_stall(m_stall), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_pc(dm_pc), .dm_rdata(dm_rdata)
   );

   dm_arbiter #(.DM_LAT(3), .AW(32), .DW(32)) u_b (
      .clk(clk), .reset(reset),
      .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_pc(b_m_pc),
      .m_stall(b_m_stall), .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .dm_en(b_dm_en), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_pc(b_dm_pc), .dm_rdata(b_dm_rdata)
   );

   // DM model for A: word memory, read data valid exactly 2 cycles after issue.
   logic [31:0] mem [0:255];
   logic        rv1 = 1'b0, rv2 = 1'b0;
   logic [31:0] rd1, rd2;
   always @(posedge clk) begin
      if (dm_en && dm_we) mem[dm_addr[9:2]] <= dm_wdata;
      rv1 <= dm_en && !dm_we;
      rd1 <= mem[dm_addr[9:2]];
      rv2 <= rv1;
      rd2 <= rd1;
   end
   assign dm_rdata = rv2 ? rd2 : 32'hDEAD_BEEF;

   // DM model for B: address-derived data, valid exactly 3 cycles after issue.
   logic        bv1 = 1'b0, bv2 = 1'b0, bv3 = 1'b0;
   logic [31:0] bd1, bd2, bd3;
   always @(posedge clk) begin
      bv1 <= b_dm_en && !b_dm_we;
      bd1 <= 32'h5A5A_0000 ^ b_dm_addr;
      bv2 <= bv1;  bd2 <= bd1;
      bv3 <= bv2;  bd3 <= bd2;
   end
   assign b_dm_rdata = bv3 ? bd3 : 32'hDEAD_BEEF;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Core handshake outputs of instance A in one call.
   task automatic expect_a(input string tag, input logic en, input logic stall,
                           input logic gnt, input logic mrv, input logic [31:0] mrd,
                           input logic drv, input logic [31:0] drd);
      check({tag, ".dm_en"},    dm_en,    en);
      check({tag, ".m_stall"},  m_stall,  stall);
      check({tag, ".d_gnt"},    d_gnt,    gnt);
      check({tag, ".m_rvalid"}, m_rvalid, mrv);
      check({tag, ".m_rdata"},  m_rdata,  mrd);
      check({tag, ".d_rvalid"}, d_rvalid, drv);
      check({tag, ".d_rdata"},  d_rdata,  drd);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      int m_n, d_n;
      reset = 1'b0;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h10; m_wdata = '0; m_pc = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0;    d_wdata = '0;
      b_m_req = 1'b0; b_m_we = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_m_pc = '0;
      b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;

      // Reset: outputs stay 0 even with m_req high.
      repeat (2) @(posedge clk);
      #1;
      sample();
      expect_a("reset", 0, 0, 0, 0, 0, 0, 0);
      check("reset.b_dm_en", b_dm_en, 1'b0);
      next_cycle();
      reset = 1'b1; m_req = 1'b0;

      // M store, no DMA: issued and acknowledged in one cycle.
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h10; m_wdata = 32'h0000_1234; m_pc = 32'h100;
      sample();
      expect_a("st", 1, 0, 0, 0, 0, 0, 0);
      check("st.dm_we",    dm_we,    1'b1);
      check("st.dm_addr",  dm_addr,  32'h10);
      check("st.dm_wdata", dm_wdata, 32'h0000_1234);
      check("st.dm_pc",    dm_pc,    32'h100);
      next_cycle();

      // M load, DM_LAT=2: stall for 2 cycles, data at t+2.
      m_we = 1'b0; m_pc = 32'h104;
      sample(); expect_a("ld_t0", 1, 1, 0, 0, 0, 0, 0);
      check("ld_t0.dm_we", dm_we, 1'b0);
      next_cycle(); sample(); expect_a("ld_t1", 0, 1, 0, 0, 0, 0, 0);
      next_cycle(); sample(); expect_a("ld_t2", 0, 0, 0, 1, 32'h0000_1234, 0, 0);
      next_cycle(); m_req = 1'b0;
      sample(); expect_a("ld_idle", 0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // Uncontended DMA write.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAAAA_5555;
      sample(); expect_a("dwr", 1, 0, 1, 0, 0, 0, 0);
      check("dwr.dm_addr", dm_addr, 32'h20);
      check("dwr.dm_pc",   dm_pc,   32'h0);
      next_cycle(); d_req = 1'b0;

      // First conflict after reset goes to M; the next one goes to DMA.
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h10; m_pc = 32'h108;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      sample(); expect_a("cf_t0", 1, 1, 0, 0, 0, 0, 0);
      check("cf_t0.dm_addr", dm_addr, 32'h10);
      check("cf_t0.dm_pc",   dm_pc,   32'h108);
      next_cycle(); sample(); expect_a("cf_t1", 0, 1, 0, 0, 0, 0, 0);
      next_cycle(); sample(); expect_a("cf_t2", 0, 0, 0, 1, 32'h0000_1234, 0, 0);
      next_cycle(); m_addr = 32'h20; m_pc = 32'h10C;
      sample(); expect_a("cf_t3", 1, 1, 1, 0, 0, 0, 0);
      check("cf_t3.dm_addr", dm_addr, 32'h20);
      check("cf_t3.dm_pc",   dm_pc,   32'h0);
      next_cycle(); d_req = 1'b0;
      sample(); expect_a("cf_t4", 0, 1, 0, 0, 0, 0, 0);
      next_cycle(); sample(); expect_a("cf_t5", 0, 1, 0, 0, 0, 1, 32'hAAAA_5555);
      next_cycle(); sample(); expect_a("cf_t6", 1, 1, 0, 0, 0, 0, 0);
      check("cf_t6.dm_pc", dm_pc, 32'h10C);
      next_cycle(); sample(); expect_a("cf_t7", 0, 1, 0, 0, 0, 0, 0);
      next_cycle(); sample(); expect_a("cf_t8", 0, 0, 0, 1, 32'hAAAA_5555, 0, 0);
      next_cycle(); m_req = 1'b0;

      // Continuous writes from both sides: grants alternate M, DMA, M, ...
      m_n = 0; d_n = 0;
      m_req = 1'b1; m_we = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
      for (int i = 0; i < 5; i++) begin
         logic        exp_m;
         logic [31:0] exp_wd;
         exp_m   = (i % 2 == 0);
         m_addr  = 32'h30 + 32'(4 * m_n);
         m_wdata = 32'h100 + 32'(m_n);
         d_wdata = 32'h200 + 32'(d_n);
         exp_wd  = exp_m ? (32'h100 + 32'(i / 2)) : (32'h200 + 32'(i / 2));
         sample();
         expect_a($sformatf("alt%0d", i), 1, !exp_m, !exp_m, 0, 0, 0, 0);
         check($sformatf("alt%0d.dm_wdata", i), dm_wdata, exp_wd);
         if (exp_m) m_n++; else d_n++;
         next_cycle();
      end
      m_req = 1'b0; d_req = 1'b0;

      // Reset during M RD_WAIT abandons the read; arbitration history is cleared.
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h10;
      sample(); expect_a("rr_t0", 1, 1, 0, 0, 0, 0, 0);
      next_cycle(); reset = 1'b0;
      sample(); expect_a("rr_hold", 0, 0, 0, 0, 0, 0, 0);
      next_cycle(); reset = 1'b1; m_req = 1'b0;
      sample(); expect_a("rr_after", 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h34; m_wdata = 32'h77;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'h88;
      sample(); expect_a("rr_cf", 1, 0, 0, 0, 0, 0, 0);
      check("rr_cf.dm_addr", dm_addr, 32'h34);
      next_cycle(); m_req = 1'b0;
      sample(); expect_a("rr_d", 1, 0, 1, 0, 0, 0, 0);
      next_cycle(); d_req = 1'b0;

      // Instance B: DMA read with DM_LAT=3 and no M traffic.
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h44;
      sample();
      check("b_t0.d_gnt",   b_d_gnt,   1'b1);
      check("b_t0.dm_en",   b_dm_en,   1'b1);
      check("b_t0.m_stall", b_m_stall, 1'b0);
      next_cycle(); b_d_req = 1'b0;
      sample();
      check("b_t1.d_rvalid", b_d_rvalid, 1'b0);
      check("b_t1.dm_en",    b_dm_en,    1'b0);
      next_cycle(); sample();
      check("b_t2.d_rvalid", b_d_rvalid, 1'b0);
      next_cycle(); sample();
      check("b_t3.d_rvalid", b_d_rvalid, 1'b1);
      check("b_t3.d_rdata",  b_d_rdata,  32'h5A5A_0044);
      check("b_t3.m_rvalid", b_m_rvalid, 1'b0);
      check("b_t3.m_stall",  b_m_stall,  1'b0);
      next_cycle(); sample();
      check("b_t4.d_rvalid", b_d_rvalid, 1'b0);
      check("b_t4.d_rdata",  b_d_rdata,  32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
